time_set_ctrl: RTL

//  User-input side of the digital clock: debounces MODE and INC push-buttons and runs a set-time FSM.

---
 rtl/time_set_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - MODE/INC button debounce and set-time FSM for the digital clock
// Define AUTO_REPEAT_EN to add hold-to-repeat on the INC key while setting.
module time_set_ctrl #(
   parameter int CLK_HZ          = 50000000,
   parameter int DEBOUNCE_MS     = 20,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_MS       = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_mode,
   input  logic        key_inc,
   input  logic [23:0] cur_time,
   output logic [23:0] edit_time,
   output logic        load,
   output logic        setting,
   output logic [1:0]  field_sel
);
   localparam int DEB_RAW    = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int DEB_CYCLES = (DEB_RAW < 1) ? 1 : DEB_RAW;
   localparam int DEB_W      = $clog2(DEB_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {RUN = 2'd0, HOUR = 2'd1, MIN = 2'd2, SEC = 2'd3} state_t;

   state_t      state, state_nxt;
   logic [23:0] edit_nxt;
   logic        load_nxt;

   // bit 0 = MODE, bit 1 = INC
   logic [1:0]       key_raw, sync1, sync2, deb_lvl, deb_dly, press;
   logic [DEB_W-1:0] deb_cnt [2];
   logic             mode_p, inc_press, inc_p;

   assign key_raw   = {key_inc, key_mode};
   assign mode_p    = press[0];
   assign inc_press = press[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= '0;
         sync2      <= '0;
         deb_lvl    <= '0;
         deb_dly    <= '0;
         press      <= '0;
         deb_cnt[0] <= '0;
         deb_cnt[1] <= '0;
      end else begin
         sync1   <= key_raw;
         sync2   <= sync1;
         deb_dly <= deb_lvl;
         press   <= deb_lvl & ~deb_dly;
         for (int k = 0; k < 2; k++) begin
            if (sync2[k] == deb_lvl[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == DEB_LAST) begin
               deb_lvl[k] <= ~deb_lvl[k];
               deb_cnt[k] <= '0;
            end else begin
               deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
            end
         end
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int RD_RAW = CLK_HZ / 1000 * REPEAT_DELAY_MS;
   localparam int RP_RAW = CLK_HZ / 1000 * REPEAT_MS;
   localparam int RD_CYC = (RD_RAW < 1) ? 1 : RD_RAW;
   localparam int RP_CYC = (RP_RAW < 1) ? 1 : RP_RAW;
   localparam int REP_W  = $clog2(((RD_CYC > RP_CYC) ? RD_CYC : RP_CYC) + 1);

   logic             rep_on, rep_first, rep_fire;
   logic [REP_W-1:0] rep_cnt;

   // rep_cnt counts cycles since the last press or repeat pulse
   assign rep_fire = rep_on && deb_lvl[1] &&
                     (rep_cnt == (rep_first ? REP_W'(RD_CYC) : REP_W'(RP_CYC)));
   assign inc_p    = inc_press | rep_fire;

   always_ff @(posedge clk) begin
      if (reset || !deb_lvl[1] || state == RUN || mode_p) begin
         rep_on    <= 1'b0;
         rep_first <= 1'b0;
         rep_cnt   <= '0;
      end else if (inc_press) begin
         rep_on    <= 1'b1;
         rep_first <= 1'b1;
         rep_cnt   <= REP_W'(1);
      end else if (rep_fire) begin
         rep_first <= 1'b0;
         rep_cnt   <= REP_W'(1);
      end else if (rep_on) begin
         rep_cnt   <= rep_cnt + REP_W'(1);
      end
   end
`else
   assign inc_p = inc_press;
`endif

   // Wraps to 00 once the field is at or beyond top, so invalid snapshots recover
   function automatic logic [7:0] bcd_inc(input logic [7:0] f, input logic [7:0] top);
      logic [7:0] v;
      v = {4'd0, f[7:4]} * 8'd10 + {4'd0, f[3:0]};
      if (v >= top)
         bcd_inc = 8'h00;
      else if (f[3:0] >= 4'd9)
         bcd_inc = {f[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {f[7:4], f[3:0] + 4'd1};
   endfunction

   always_comb begin
      state_nxt = state;
      edit_nxt  = edit_time;
      load_nxt  = 1'b0;
      if (mode_p) begin
         case (state)
            RUN: begin
               state_nxt = HOUR;
               edit_nxt  = cur_time;
            end
            HOUR:    state_nxt = MIN;
            MIN:     state_nxt = SEC;
            default: begin
               state_nxt = RUN;
               load_nxt  = 1'b1;
            end
         endcase
      end else if (inc_p) begin
         case (state)
            HOUR:    edit_nxt[23:16] = bcd_inc(edit_time[23:16], 8'd23);
            MIN:     edit_nxt[15:8]  = bcd_inc(edit_time[15:8],  8'd59);
            SEC:     edit_nxt[7:0]   = bcd_inc(edit_time[7:0],   8'd59);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         edit_time <= '0;
         load      <= 1'b0;
         setting   <= 1'b0;
         field_sel <= 2'd0;
      end else begin
         state     <= state_nxt;
         edit_time <= edit_nxt;
         load      <= load_nxt;
         setting   <= (state_nxt != RUN);
         field_sel <= state_nxt;
      end
   end
endmodule
